// File: rtl/memory_unit_if.sv
// rtl/memory_unit_if.sv - bus, control and program-loader signals of the SAP-1 memory stage
interface memory_unit_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] bus_in;
   logic [DATA_W-1:0] bus_out;
   logic              bus_oe;
   logic              mar_addr_load_n;
   logic              mar_mem_load_n;
   logic              ram_en_n;
   logic              ram_load_n;
   logic              prog_start;
   logic              prog_valid;
   logic [DATA_W-1:0] prog_data;
   logic              prog_ready;
   logic              prog_busy;
   logic              prog_done;
   logic [ADDR_W-1:0] mar_q;

   modport master (
      output bus_in, mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n,
             prog_start, prog_valid, prog_data,
      input  bus_out, bus_oe, prog_ready, prog_busy, prog_done, mar_q
   );

   modport slave (
      input  bus_in, mar_addr_load_n, mar_mem_load_n, ram_en_n, ram_load_n,
             prog_start, prog_valid, prog_data,
      output bus_out, bus_oe, prog_ready, prog_busy, prog_done, mar_q
   );
endinterface

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - SAP-1 memory stage: MAR, MDR, 16x8 RAM and a program loader
module memory_unit #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   memory_unit_if.slave mu
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              loading;

   assign loading = (state_q == LOAD);

   // Next-state for the loader FSM, registers and RAM; all writes use pre-edge MAR/MDR
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      mem_d   = mem_q;

      if (!loading) begin
         if (!mu.mar_addr_load_n) mar_d = mu.bus_in[ADDR_W-1:0];
         if (!mu.mar_mem_load_n)  mdr_d = mu.bus_in;
         if (!mu.ram_load_n)      mem_d[mar_q] = mdr_q;
      end

      unique case (state_q)
         IDLE, DONE: begin
            if (mu.prog_start) begin
               state_d = LOAD;
               ptr_d   = '0;
            end
         end
         LOAD: begin
            // prog_ready is constant high in LOAD, so valid alone accepts a byte
            if (mu.prog_valid) begin
               mem_d[ptr_q] = mu.prog_data;
               ptr_d        = ptr_q + 1'b1;
               if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset also clears the whole RAM, aborting any load in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         mem_q   <= mem_d;
      end
   end

   assign mu.bus_out    = mem_q[mar_q];
   assign mu.bus_oe     = !mu.ram_en_n && !loading;
   assign mu.prog_ready = loading;
   assign mu.prog_busy  = loading;
   assign mu.prog_done  = (state_q == DONE);
   assign mu.mar_q      = mar_q;
endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- SAP-1 memory stage, directly downstream of the control block.
- Consumes the active-low control lines \L_MA, \L_MD, \CE and \L_R, and exchanges data with the shared 8-bit bus.
- Holds the memory address register (MAR), the memory data register (MDR) and a 16x8 register-file RAM.
- Adds an auto-incrementing program loader that fills RAM over a valid/ready handshake before the CPU runs.

Parameters:
ADDR_W, 4, MAR and RAM address width (depth = 2**ADDR_W)
DATA_W, 8, bus, MDR and RAM word width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
bus_in  input  DATA_W  shared bus value (driven by PC, IR or registers)
bus_out  output  DATA_W  RAM[MAR] read data
bus_oe  output  1  high when bus_out must drive the bus
mar_addr_load_n  input  1  \L_MA: load MAR from bus_in[ADDR_W-1:0]
mar_mem_load_n  input  1  \L_MD: load MDR from bus_in
ram_en_n  input  1  \CE: drive RAM[MAR] onto bus
ram_load_n  input  1  \L_R: write MDR into RAM[MAR]
prog_start  input  1  pulse: begin loading from address 0
prog_valid  input  1  loader byte valid
prog_data  input  DATA_W  loader byte
prog_ready  output  1  loader can accept a byte
prog_busy  output  1  loader active; CPU-side controls ignored
prog_done  output  1  all 2**ADDR_W words loaded
mar_q  output  ADDR_W  current MAR, for debug and LEDs

Behaviour:
Reset (async, rst=1):
- mar=0, mdr=0, all RAM words=0, loader state=IDLE, ptr=0.
- bus_oe=0, prog_ready=0, prog_busy=0, prog_done=0.
- Reset asserted mid-load aborts the load; all RAM returns to 0.

CPU side (when loader state != LOAD), all actions on the rising edge:
- !mar_addr_load_n: mar <= bus_in[ADDR_W-1:0]; upper bits are ignored.
- !mar_mem_load_n: mdr <= bus_in.
- !ram_load_n: mem[mar] <= mdr.
- Every write or load samples the pre-edge values of mar and mdr. When MAR load, MDR load and RAM write coincide, the write lands at the old MAR with the old MDR.
- Read path is combinational: bus_out = mem[mar]; bus_oe = !ram_en_n.
- If ram_en_n and ram_load_n are both low in the same cycle, the write occurs, bus_out shows the pre-write word that cycle and the new word the next cycle.

Loader FSM (states IDLE, LOAD, DONE):
- IDLE: on prog_start -> LOAD, ptr <= 0.
- LOAD:
  - prog_ready=1, prog_busy=1.
  - All four control inputs are ignored and bus_oe is forced to 0.
  - Each cycle with prog_valid & prog_ready: mem[ptr] <= prog_data, ptr <= ptr+1.
  - The acceptance at ptr = 2**ADDR_W-1 moves to DONE; ptr wraps to 0.
  - prog_start during LOAD is ignored, with no restart.
  - prog_valid low holds state with no write; the loader waits indefinitely.
- DONE:
  - prog_done=1 and stays asserted.
  - prog_start -> LOAD with ptr <= 0 and prog_done cleared on that edge.
  - RAM contents are retained, and reloading overwrites them.
- MAR and MDR are untouched by the loader. mar_q always reflects mar.
- Latency: a control-driven load or write is visible the cycle after the edge. A loader byte is readable via \CE one cycle after its acceptance edge, once the loader has left LOAD.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all controls high -> mar_q=0, bus_oe=0, prog_done=0; reading any address after MAR loads returns 8'h00.
- Program load: prog_start pulse, then 16 bytes 8'h10..8'h1F with prog_valid held high -> prog_ready high 16 cycles, prog_done=1 on the 17th cycle; then \L_MA with bus_in=8'hF5 and \CE -> bus_out=8'h15, bus_oe=1.
- Back-pressure: during LOAD drop prog_valid for 3 cycles after byte 4 -> no write, ptr holds at 5; byte 5 lands at address 5.
- STA path: \L_MA with bus_in=8'h0A, then \L_MD with 8'hC3, then \L_R -> next cycle \CE gives bus_out=8'hC3 at address 10. Simultaneous \L_MA=8'h02 with \L_R -> write goes to old address 10, address 2 unchanged.
- Ignore during load: assert \L_R, \L_MA and \CE while prog_busy=1 -> mar_q unchanged, bus_oe=0, no stray RAM write.
- Reset mid-load: rst pulse after 7 bytes accepted -> prog_busy=0, prog_done=0, address 3 reads 8'h00; a new prog_start restarts at address 0.
